pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Replaces the scattered per-instruction stall state machines and the load-use stall logic with one arbitrated FSM.
- Drives the PC enable, the IF/ID hold and the ID/EX synchronous clear.
- Inputs are decode-stage control flags and EX-stage destination info.

Parameters:
- BR_WAIT, 3: bubble cycles after a conditional branch (BEQ/BGTZ/BGEZ/BNE/BLEZ) leaves decode.
- J_WAIT, 2: bubble cycles for J.
- JAL_WAIT, 3: bubble cycles for JAL; covers the link write reaching WB.
- JR_WAIT, 2: bubble cycles for JR.
- CNT_W, 3: wait-counter width. Every *_WAIT must be in 1..2^CNT_W-1; a value of 0 behaves as 1.

Ports:
- clk  in  1  pipeline clock; all state updates on negedge clk, matching the pipeline registers
- init  in  1  reset, asynchronous, active-low
- dec_br  in  1  OR of decoded BEQ/BGTZ/BGEZ/BNE/BLEZ
- dec_j  in  1  decoded J
- dec_jal  in  1  decoded JAL
- dec_jr  in  1  decoded JR
- dec_rs  in  5  decode rs field
- dec_rt  in  5  decode rt field
- ex_mem_read  in  1  EX-stage instruction writes a loaded value to the register file
- ex_rw  in  5  EX-stage destination register
- pc_en  out  1  PC update enable
- if_id_en  out  1  IF/ID load enable
- id_ex_clear  out  1  ID/EX synchronous clear (bubble insert)
- busy  out  1  FSM not in IDLE
- stall_cause  out  3  0 none, 1 load-use, 2 branch, 3 J, 4 JAL, 5 JR

Behaviour:
- Reset (init=0, asynchronous):
  - state IDLE, counter 0, cause register 0.
  - Outputs pc_en=1, if_id_en=1, id_ex_clear=0, busy=0, stall_cause=0.
- Load-use hazard: lu = ex_mem_read && ex_rw!=0 && (ex_rw==dec_rs || ex_rw==dec_rt). Combinational.
- ctrl = dec_jal | dec_jr | dec_j | dec_br.
- States: IDLE, HOLD, RELEASE.
- IDLE, Mealy outputs:
  - lu=1: pc_en=0, if_id_en=0, id_ex_clear=1, stall_cause=1. Stay IDLE. This is a one-cycle stall; it repeats while lu persists.
  - else ctrl=1: pc_en=0, if_id_en=0, id_ex_clear=0, so the control instruction enters ID/EX once.
    - Latch cause using priority JAL > JR > J > BR.
    - Load counter with the matching WAIT value.
    - Go to HOLD.
  - else: pc_en=1, if_id_en=1, id_ex_clear=0, stall_cause=0.
- lu and ctrl together in IDLE: load stall wins. ctrl is re-evaluated on the following cycle.
- HOLD:
  - Outputs pc_en=0, if_id_en=0, id_ex_clear=1, busy=1, stall_cause=latched cause.
  - Counter decrements each negedge; when counter==1, go to RELEASE.
  - Decode flags and lu are ignored; the stale decode copy in IF/ID must not retrigger.
- RELEASE, one cycle:
  - Outputs pc_en=1, if_id_en=1, id_ex_clear=1 (squashes the stale decode copy), busy=1.
  - Next state IDLE; cause register clears.
- Latency: a control instruction at decode cycle D produces WAIT bubbles (D+1..D+WAIT), RELEASE at D+WAIT+1, normal flow at D+WAIT+2.
- Reset asserted mid-HOLD or mid-RELEASE: immediate return to IDLE with reset output values. No partial sequence resumes.
- Outputs are glitch-free functions of state plus registered/decoded inputs. No level-sensitive latches. No procedural writes from multiple always blocks.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined, adds two outputs:
  - stall_cycles (32b): increments on every negedge with pc_en=0.
  - flush_events (32b): increments on each IDLE->HOLD transition.
  - Both saturate at 32'hFFFFFFFF and reset to 0 on init.
- When undefined, these ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - state encoding (IDLE=2'd0, HOLD=2'd1, RELEASE=2'd2)
  - stall_cause codes (CAUSE_NONE..CAUSE_JR)
  - REG_ZERO=5'd0
- One natural sub-module, load_use_detect: purely the lu compare, so the forwarding unit can reuse it.

Test Plan:
- Reset: init=0 at time 0 then released -> pc_en=1, if_id_en=1, id_ex_clear=0, busy=0, stall_cause=0.
- Load-use: ex_mem_read=1, ex_rw=8, dec_rs=8 for one cycle -> exactly one cycle with pc_en=0, if_id_en=0, id_ex_clear=1, stall_cause=1. With ex_rw=0 instead -> no stall.
- Branch: dec_br=1 for one cycle, defaults -> D: clear=0, pc_en=0; D+1..D+3: clear=1, pc_en=0, cause=2; D+4: pc_en=1, clear=1; D+5: IDLE.
- Priority: dec_jal=1 and dec_br=1 together -> cause=4, 3 bubbles. Then lu=1 together with dec_j=1 -> load stall first, then J sequence with 2 bubbles.
- Reset mid-HOLD: assert init=0 during the second bubble of a JAL -> outputs return to reset values asynchronously; after release, IDLE with no residual bubbles.
- With HAZARD_PERF_CNT_EN: one branch plus one load stall -> flush_events=1, stall_cycles=5 (1 branch detect cycle + 3 branch bubbles + 1 load-use stall).

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard sequencer: FSM states, stall causes, r0.
package pipe_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE = 3'd0,
    CAUSE_LU   = 3'd1,
    CAUSE_BR   = 3'd2,
    CAUSE_J    = 3'd3,
    CAUSE_JAL  = 3'd4,
    CAUSE_JR   = 3'd5
  } cause_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use.sv
// Load-use compare: EX-stage load targets a register the decode instruction reads.
// Kept standalone so the forwarding unit can share it.
module load_use_detect
  import pipe_pkg::*;
(
  input  logic       mem_read,
  input  logic [4:0] rw,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  output logic       lu
);

  assign lu = mem_read && (rw != REG_ZERO) && ((rw == rs) || (rw == rt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer: load-use stalls plus branch/jump bubble sequences.
// Optional HAZARD_PERF_CNT_EN adds saturating stall_cycles / flush_events counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int BR_WAIT  = 3,
  parameter int J_WAIT   = 2,
  parameter int JAL_WAIT = 3,
  parameter int JR_WAIT  = 2,
  parameter int CNT_W    = 3
) (
  input  logic        clk,
  input  logic        init,
  input  logic        dec_br,
  input  logic        dec_j,
  input  logic        dec_jal,
  input  logic        dec_jr,
  input  logic [4:0]  dec_rs,
  input  logic [4:0]  dec_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rw,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        id_ex_clear,
  output logic        busy,
  output logic [2:0]  stall_cause
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
`endif
);

  // A zero wait still has to produce one bubble.
  function automatic logic [CNT_W-1:0] wval(input int w);
    return (w < 1) ? CNT_W'(1) : CNT_W'(w);
  endfunction

  localparam logic [CNT_W-1:0] BR_CNT  = wval(BR_WAIT);
  localparam logic [CNT_W-1:0] J_CNT   = wval(J_WAIT);
  localparam logic [CNT_W-1:0] JAL_CNT = wval(JAL_WAIT);
  localparam logic [CNT_W-1:0] JR_CNT  = wval(JR_WAIT);

  state_t           state;
  cause_t           cause_q;
  logic [CNT_W-1:0] cnt;
  logic             lu;
  logic             ctrl;
  cause_t           nxt_cause;
  logic [CNT_W-1:0] nxt_cnt;

  load_use_detect u_lu (
    .mem_read (ex_mem_read),
    .rw       (ex_rw),
    .rs       (dec_rs),
    .rt       (dec_rt),
    .lu       (lu)
  );

  assign ctrl = dec_jal | dec_jr | dec_j | dec_br;

  always_comb begin
    nxt_cause = CAUSE_BR;
    nxt_cnt   = BR_CNT;
    if (dec_jal) begin
      nxt_cause = CAUSE_JAL;
      nxt_cnt   = JAL_CNT;
    end else if (dec_jr) begin
      nxt_cause = CAUSE_JR;
      nxt_cnt   = JR_CNT;
    end else if (dec_j) begin
      nxt_cause = CAUSE_J;
      nxt_cnt   = J_CNT;
    end
  end

  always_ff @(negedge clk or negedge init) begin
    if (!init) begin
      state   <= IDLE;
      cause_q <= CAUSE_NONE;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (!lu && ctrl) begin
          state   <= HOLD;
          cause_q <= nxt_cause;
          cnt     <= nxt_cnt;
        end
        HOLD: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt <= CNT_W'(1)) state <= RELEASE;
        end
        RELEASE: begin
          state   <= IDLE;
          cause_q <= CAUSE_NONE;
          cnt     <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Mealy in IDLE only; HOLD ignores decode so the stale IF/ID copy cannot retrigger.
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    id_ex_clear = 1'b0;
    stall_cause = CAUSE_NONE;
    if (init) begin
      case (state)
        IDLE: if (lu) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_clear = 1'b1;
          stall_cause = CAUSE_LU;
        end else if (ctrl) begin
          pc_en    = 1'b0;
          if_id_en = 1'b0;
        end
        HOLD: begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_clear = 1'b1;
          stall_cause = cause_q;
        end
        RELEASE: begin
          id_ex_clear = 1'b1;
          stall_cause = cause_q;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(negedge clk or negedge init) begin
    if (!init) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (!pc_en && stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
      if (state == IDLE && !lu && ctrl && flush_events != 32'hFFFF_FFFF)
        flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule
